// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button conditioning and run/lap/stop FSM for the stopwatch datapath
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start_stop,
  input  logic       i_lap,
  input  logic       i_clear,
  output logic       o_en,
  output logic       o_clear,
  output logic       o_freeze,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  // The counter flips the accepted level on the edge where it would have
  // reached DEBOUNCE_CYCLES, so it only ever needs to hold DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = start_stop, bit 1 = lap, bit 2 = clear.
  logic [2:0] raw;
  logic [2:0] press;

  assign raw = {i_clear, i_lap, i_start_stop};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic          sync1;
    logic          sync2;
    logic          accepted;
    logic          event_q;
    logic [CW-1:0] cnt;

    // Synchronise, debounce and turn an accepted 0->1 change into a one-cycle press event.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        sync1    <= 1'b0;
        sync2    <= 1'b0;
        accepted <= 1'b0;
        event_q  <= 1'b0;
        cnt      <= '0;
      end else begin
        sync1   <= raw[b];
        sync2   <= sync1;
        event_q <= 1'b0;
        if (sync2 == accepted) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          accepted <= sync2;
          cnt      <= '0;
          event_q  <= sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign press[b] = event_q;
  end

  state_t state;
  state_t next_state;
  logic   take_clear;
  logic   en_d;
  logic   freeze_d;
  logic   clear_d;

  // State register plus registered Moore outputs, all cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      o_en     <= 1'b0;
      o_freeze <= 1'b0;
      o_clear  <= 1'b0;
    end else begin
      state    <= next_state;
      o_en     <= en_d;
      o_freeze <= freeze_d;
      o_clear  <= clear_d;
    end
  end

  // Next state: start_stop outranks lap, lap outranks clear; events a state ignores fall through.
  always_comb begin
    next_state = state;
    take_clear = 1'b0;
    unique case (state)
      IDLE: begin
        if (press[0]) begin
          next_state = RUN;
        end else if (press[2]) begin
          next_state = IDLE;
          take_clear = 1'b1;
        end
      end
      RUN: begin
        if (press[0])      next_state = STOP;
        else if (press[1]) next_state = LAP;
      end
      LAP: begin
        if (press[0])      next_state = STOP;
        else if (press[1]) next_state = RUN;
      end
      STOP: begin
        if (press[0]) begin
          next_state = RUN;
        end else if (press[2]) begin
          next_state = IDLE;
          take_clear = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output values for the state being entered, so they register alongside it.
  always_comb begin
    en_d     = (next_state == RUN) || (next_state == LAP);
    freeze_d = (next_state == LAP);
    clear_d  = take_clear;
  end

  assign o_state = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with a window-based reference model
module tb_stopwatch_ctrl;

  localparam int D = 4;

  logic       i_clk;
  logic       i_reset;
  logic       i_start_stop;
  logic       i_lap;
  logic       i_clear;
  logic       o_en;
  logic       o_clear;
  logic       o_freeze;
  logic [1:0] o_state;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start_stop (i_start_stop),
    .i_lap        (i_lap),
    .i_clear      (i_clear),
    .o_en         (o_en),
    .o_clear      (o_clear),
    .o_freeze     (o_freeze),
    .o_state      (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;
  int clr_seen = 0;

  // Reference model: raw samples per button, newest first; accepted level
  // flips once D consecutive synchronised samples disagree with it.
  bit mhist [3][D+1];
  bit macc  [3];
  bit mpend [3];
  int mstate;
  bit mclear;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k <= D; k++) mhist[b][k] = 1'b0;
      macc[b]  = 1'b0;
      mpend[b] = 1'b0;
    end
    mstate = 0;
    mclear = 1'b0;
  endtask

  task automatic model_step(input bit r0, input bit r1, input bit r2);
    bit raw [3];
    bit all_diff;
    raw[0] = r0; raw[1] = r1; raw[2] = r2;
    mclear = 1'b0;
    if (mpend[0]) begin
      mstate = (mstate == 0 || mstate == 3) ? 1 : 3;
    end else if (mpend[1] && (mstate == 1 || mstate == 2)) begin
      mstate = (mstate == 1) ? 2 : 1;
    end else if (mpend[2] && (mstate == 0 || mstate == 3)) begin
      mstate = 0;
      mclear = 1'b1;
    end
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= D; k++) if (mhist[b][k] == macc[b]) all_diff = 1'b0;
      mpend[b] = 1'b0;
      if (all_diff) begin
        macc[b]  = !macc[b];
        mpend[b] = macc[b];
      end
      for (int k = D; k >= 1; k--) mhist[b][k] = mhist[b][k-1];
      mhist[b][0] = raw[b];
    end
  endtask

  function automatic int pack_out(input int st, input bit en, input bit fr, input bit cl);
    return (st << 3) | (int'(en) << 2) | (int'(fr) << 1) | int'(cl);
  endfunction

  // One clock: model advances at the edge, DUT compared at the falling edge.
  task automatic tick();
    @(posedge i_clk);
    if (i_reset) model_reset();
    else model_step(i_start_stop, i_lap, i_clear);
    @(negedge i_clk);
    if (o_clear) clr_seen++;
    chk("model", pack_out(int'(o_state), o_en, o_freeze, o_clear),
        pack_out(mstate, (mstate == 1 || mstate == 2), (mstate == 2), mclear));
  endtask

  task automatic set_btn(input bit s, input bit l, input bit c);
    i_start_stop = s;
    i_lap        = l;
    i_clear      = c;
  endtask

  typedef struct {
    bit ss;
    bit lp;
    bit cl;
    int hold;
    int exp_state;
    bit exp_en;
    bit exp_fr;
    int exp_clears;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0,  8, 3, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0,  8, 1, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0,  8, 2, 1'b1, 1'b1, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0,  8, 1, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0,  8, 2, 1'b1, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0,  8, 3, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1,  8, 0, 1'b0, 1'b0, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1,  8, 0, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0,  8, 0, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0,  8, 1, 1'b1, 1'b0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b1,  8, 1, 1'b1, 1'b0, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b0,  8, 3, 1'b0, 1'b0, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 40, 1, 1'b1, 1'b0, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b0,  8, 2, 1'b1, 1'b1, 0};

    i_reset = 1'b1;
    set_btn(1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    chk("reset_outputs", pack_out(int'(o_state), o_en, o_freeze, o_clear), 0);
    tick();
    tick();
    i_reset = 1'b0;
    repeat (20) tick();

    // Latency: state changes on the 6th edge after the first sampling edge.
    set_btn(1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    chk("latency_before", int'(o_state), 0);
    tick();
    chk("latency_state", int'(o_state), 1);
    chk("latency_en", int'(o_en), 1);
    set_btn(1'b0, 1'b0, 1'b0);
    repeat (10) tick();

    for (int i = 0; i < 14; i++) begin
      if (i == 12) begin
        for (int g = 0; g < 10; g++) begin
          set_btn(1'b1, 1'b0, 1'b0);
          repeat (3) tick();
          set_btn(1'b0, 1'b0, 1'b0);
          repeat (3) tick();
        end
        chk("glitch_state", int'(o_state), 3);
      end
      clr_seen = 0;
      set_btn(tbl[i].ss, tbl[i].lp, tbl[i].cl);
      repeat (tbl[i].hold) tick();
      set_btn(1'b0, 1'b0, 1'b0);
      repeat (10) tick();
      chk($sformatf("vec%0d_state", i), int'(o_state), tbl[i].exp_state);
      chk($sformatf("vec%0d_en", i), int'(o_en), int'(tbl[i].exp_en));
      chk($sformatf("vec%0d_freeze", i), int'(o_freeze), int'(tbl[i].exp_fr));
      chk($sformatf("vec%0d_clears", i), clr_seen, tbl[i].exp_clears);
    end

    // Asynchronous reset from LAP, with start_stop held through its release.
    chk("pre_async_lap", int'(o_state), 2);
    #2;
    i_reset = 1'b1;
    set_btn(1'b1, 1'b0, 1'b0);
    #1;
    chk("async_reset", pack_out(int'(o_state), o_en, o_freeze, o_clear), 0);
    model_reset();
    tick();
    i_reset = 1'b0;
    repeat (10) tick();
    chk("held_through_reset", int'(o_state), 1);
    set_btn(1'b0, 1'b0, 1'b0);
    repeat (10) tick();

    // Random button activity against the model, with occasional resets.
    for (int seg = 0; seg < 120; seg++) begin
      int dur;
      dur = $urandom_range(1, 9);
      set_btn(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 39) == 0) begin
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
      end
      repeat (dur) tick();
    end
    set_btn(1'b0, 1'b0, 1'b0);
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
